bmf_latent_decoder: RTL

Runtime-programmable Boolean-matrix-factorization decompressor: it expands a K-bit latent code into an M-bit approximate output using a loadable K×M basis matrix. It is the H-side counterpart to the hard-wired latent encoders in approximate-partition netlists. It lets one decoder instance serve any partition and any basis size chosen by the factorization flow, without resynthesis. It sits downstream of a partition's compressor stage and feeds the partition's output bits to the rest of the datapath.

---
 rtl/bmf_pkg.sv | 24 ++
 rtl/bmf_semiring_dot.sv | 25 ++
 rtl/bmf_latent_decoder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bmf_pkg.sv
// rtl/bmf_pkg.sv - shared types and limits for the BMF latent decoder (build option: BMF_XOR_SEMIRING_EN)
package bmf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } bmf_state_e;

  localparam int BMF_K_DEFAULT = 3;
  localparam int BMF_M_DEFAULT = 4;

  localparam int BMF_K_MIN = 1;
  localparam int BMF_K_MAX = 8;
  localparam int BMF_M_MIN = 1;
  localparam int BMF_M_MAX = 32;

  // True when the latent width and output width are inside the supported range.
  function automatic bit bmf_params_ok(input int k, input int m);
    return (k >= BMF_K_MIN) && (k <= BMF_K_MAX) && (m >= BMF_M_MIN) && (m <= BMF_M_MAX);
  endfunction

endpackage

// File: rtl/bmf_semiring_dot.sv
// rtl/bmf_semiring_dot.sv - latent code times basis matrix, OR semiring or XOR (BMF_XOR_SEMIRING_EN)
module bmf_semiring_dot #(
  parameter int K = 3,
  parameter int M = 4
) (
  input  logic [K-1:0]   k,
  input  logic [K*M-1:0] h,
  output logic [M-1:0]   y
);

  // Accumulate the basis rows selected by the set bits of k.
  always_comb begin
    y = '0;
    for (int i = 0; i < K; i++) begin
      if (k[i]) begin
`ifdef BMF_XOR_SEMIRING_EN
        y = y ^ h[i*M +: M];
`else
        y = y | h[i*M +: M];
`endif
      end
    end
  end

endmodule

// File: rtl/bmf_latent_decoder.sv
// rtl/bmf_latent_decoder.sv - loadable-basis latent decoder; semiring selected by BMF_XOR_SEMIRING_EN
module bmf_latent_decoder
  import bmf_pkg::*;
#(
  parameter int K = BMF_K_DEFAULT,
  parameter int M = BMF_M_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [M-1:0] cfg_data,
  input  logic         cfg_last,
  output logic         cfg_err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         loaded
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if (!bmf_params_ok(K, M)) begin : g_param_check
    $error("bmf_latent_decoder: K or M outside supported range");
  end

  bmf_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  row;
  logic           err_q, err_d;
  logic           h_we;
  logic [K*M-1:0] h_q;
  logic [M-1:0]   dot_y;
  logic           in_fire;

  assign cfg_err = err_q;
  assign in_fire = in_valid && in_ready;

  bmf_semiring_dot #(.K(K), .M(M)) u_dot (
    .k (in_k),
    .h (h_q),
    .y (dot_y)
  );

  // State, row counter and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: row sequencing during loads, handshake enables per state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    h_we      = 1'b0;
    row       = (state_q == EMPTY) ? '0 : cnt_q;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    loaded    = 1'b0;
    case (state_q)
      EMPTY, LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          h_we = 1'b1;
          if (row == '0) err_d = 1'b0;
          if (row == CW'(K - 1)) begin
            cnt_d = '0;
            if (cfg_last) begin
              state_d = RUN;
            end else begin
              // No wrap to row 0: an unterminated load is rejected.
              err_d   = 1'b1;
              state_d = EMPTY;
            end
          end else if (cfg_last) begin
            err_d   = 1'b1;
            state_d = EMPTY;
            cnt_d   = '0;
          end else begin
            state_d = LOAD;
            cnt_d   = row + CW'(1);
          end
        end
      end
      RUN: begin
        loaded   = 1'b1;
        in_ready = !out_valid || out_ready;
        if (cfg_valid) state_d = DRAIN;
      end
      DRAIN: begin
        // The pending word must leave before H may be overwritten.
        loaded = 1'b1;
        if (!out_valid || out_ready) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (rst) begin
      cfg_ready = 1'b0;
      in_ready  = 1'b0;
    end
  end

  // Basis storage, one row written per accepted cfg beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
    end else if (h_we) begin
      h_q[int'(row)*M +: M] <= cfg_data;
    end
  end

  // Output register: capture on code accept, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= dot_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
